// File: rtl/test_pattern_pkg.sv
// Shared constants for the test pattern generator: mode encodings, FSM states
// and the PRBS-15 (x^15 + x^14 + 1) seed, taps and single-step function.
package test_pattern_pkg;

    localparam logic [1:0] MODE_SQUARE = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_CONST  = 2'd2;
    localparam logic [1:0] MODE_PRBS   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [14:0] PRBS_SEED  = 15'h7FFF;
    localparam int          PRBS_TAP_A = 15;
    localparam int          PRBS_TAP_B = 14;

    // Fibonacci step: the oldest bit sits in [14], the new bit enters at [0].
    function automatic logic [14:0] prbs15_step(input logic [14:0] s);
        return {s[13:0], s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1]};
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS-15 generator producing SAMP_W new bits per advance, first bit in the MSB.
// Only compiled when TEST_PATTERN_GEN_PRBS_EN is defined.
`ifdef TEST_PATTERN_GEN_PRBS_EN
module prbs15_lfsr
    import test_pattern_pkg::*;
#(
    parameter int SAMP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              advance,
    output logic [SAMP_W-1:0] prbs_out
);

    logic [14:0] state_reg;
    logic [14:0] walk;

    // restart lets the very first word of a run come straight from the seed
    always_comb begin
        walk     = restart ? PRBS_SEED : state_reg;
        prbs_out = '0;
        for (int i = SAMP_W - 1; i >= 0; i--) begin
            walk        = prbs15_step(walk);
            prbs_out[i] = walk[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PRBS_SEED;
        end else if (advance) begin
            state_reg <= walk;
        end
    end

endmodule
`endif

// File: rtl/test_pattern_gen.sv
// Streaming I/Q test pattern generator: square, ramp, constant and PRBS modes.
// PRBS mode is real only with TEST_PATTERN_GEN_PRBS_EN defined; otherwise it emits zeros.
module test_pattern_gen
    import test_pattern_pkg::*;
#(
    parameter int SAMP_W = 16,
    parameter int PER_W  = 16
) (
    input  logic                radio_clk,
    input  logic                radio_rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PER_W-1:0]    half_period,
    input  logic [SAMP_W-1:0]   amplitude,
    output logic [2*SAMP_W-1:0] tx_tdata,
    output logic                tx_tvalid,
    input  logic                tx_tready
);

    state_t            state_reg;
    logic              en_prev_reg;
    logic [1:0]        mode_reg;
    logic [PER_W-1:0]  half_period_reg;
    logic [SAMP_W-1:0] amplitude_reg;
    logic [PER_W-1:0]  phase_cnt_reg;
    logic              phase_low_reg;
    logic [SAMP_W-1:0] ramp_reg;

    logic start;
    logic xfer;
    logic launch;

    assign start  = (state_reg == ST_IDLE) && en && !en_prev_reg;
    assign xfer   = tx_tvalid && tx_tready;
    assign launch = start || ((state_reg == ST_RUN) && xfer && en);

`ifdef TEST_PATTERN_GEN_PRBS_EN
    logic [SAMP_W-1:0] prbs_bits;
    logic [SAMP_W-1:0] prbs_prev_reg;

    prbs15_lfsr #(
        .SAMP_W(SAMP_W)
    ) u_prbs (
        .clk     (radio_clk),
        .rst_n   (radio_rst_n),
        .restart (start),
        .advance (launch),
        .prbs_out(prbs_bits)
    );
`endif

    // Generator state holds the *next* beat; on a start it is taken from reset values
    // and the freshly sampled inputs so the first beat appears one cycle after en rises.
    logic [1:0]        cur_mode;
    logic [PER_W-1:0]  cur_hp;
    logic [SAMP_W-1:0] cur_amp;
    logic [PER_W-1:0]  hp_last;
    logic [PER_W-1:0]  cnt_base;
    logic [PER_W-1:0]  cnt_next;
    logic              low_base;
    logic              low_next;
    logic [SAMP_W-1:0] ramp_base;
    logic [SAMP_W-1:0] lane_i;
    logic [SAMP_W-1:0] lane_q;

    always_comb begin
        cur_mode  = start ? mode        : mode_reg;
        cur_hp    = start ? half_period : half_period_reg;
        cur_amp   = start ? amplitude   : amplitude_reg;
        cnt_base  = start ? '0   : phase_cnt_reg;
        low_base  = start ? 1'b0 : phase_low_reg;
        ramp_base = start ? '0   : ramp_reg;
        hp_last   = (cur_hp == '0) ? '0 : cur_hp - PER_W'(1);
        if (cnt_base == hp_last) begin
            cnt_next = '0;
            low_next = !low_base;
        end else begin
            cnt_next = cnt_base + PER_W'(1);
            low_next = low_base;
        end
        lane_i = '0;
        lane_q = '0;
        case (cur_mode)
            MODE_SQUARE: begin
                lane_i = low_base ? '0 : cur_amp;
                lane_q = low_base ? '0 : cur_amp;
            end
            MODE_RAMP: begin
                lane_i = ramp_base;
                lane_q = ~ramp_base;
            end
            MODE_CONST: begin
                lane_i = cur_amp;
                lane_q = cur_amp;
            end
            default: begin
`ifdef TEST_PATTERN_GEN_PRBS_EN
                lane_i = prbs_bits;
                lane_q = start ? '0 : prbs_prev_reg;
`else
                lane_i = '0;
                lane_q = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            state_reg       <= ST_IDLE;
            en_prev_reg     <= 1'b0;
            mode_reg        <= '0;
            half_period_reg <= '0;
            amplitude_reg   <= '0;
            phase_cnt_reg   <= '0;
            phase_low_reg   <= 1'b0;
            ramp_reg        <= '0;
            tx_tdata        <= '0;
            tx_tvalid       <= 1'b0;
`ifdef TEST_PATTERN_GEN_PRBS_EN
            prbs_prev_reg   <= '0;
`endif
        end else begin
            en_prev_reg <= en;
            if (start) begin
                mode_reg        <= mode;
                half_period_reg <= half_period;
                amplitude_reg   <= amplitude;
            end
            if (launch) begin
                tx_tdata      <= {lane_i, lane_q};
                tx_tvalid     <= 1'b1;
                phase_cnt_reg <= cnt_next;
                phase_low_reg <= low_next;
                ramp_reg      <= ramp_base + SAMP_W'(1);
`ifdef TEST_PATTERN_GEN_PRBS_EN
                prbs_prev_reg <= lane_i;
`endif
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (!en && xfer) begin
                        state_reg <= ST_IDLE;
                        tx_tvalid <= 1'b0;
                        tx_tdata  <= '0;
                    end else if (!en) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        state_reg <= ST_IDLE;
                        tx_tvalid <= 1'b0;
                        tx_tdata  <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: a 16-bit instance for the main scenarios
// and a narrow 4-bit / 3-bit instance to reach the ramp and half-period wrap points.
module tb_test_pattern_gen;
    import test_pattern_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        tready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] hp = 16'd0;
    logic [15:0] amp = 16'd0;
    logic [31:0] tdata;
    logic        tvalid;
    logic [2:0]  hp_s = 3'd0;
    logic [3:0]  amp_s = 4'd0;
    logic [7:0]  tdata_s;
    logic        tvalid_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    test_pattern_gen #(.SAMP_W(16), .PER_W(16)) dut (
        .radio_clk(clk), .radio_rst_n(rst_n), .en(en), .mode(mode),
        .half_period(hp), .amplitude(amp), .tx_tdata(tdata),
        .tx_tvalid(tvalid), .tx_tready(tready)
    );

    test_pattern_gen #(.SAMP_W(4), .PER_W(3)) dut_s (
        .radio_clk(clk), .radio_rst_n(rst_n), .en(en), .mode(mode),
        .half_period(hp_s), .amplitude(amp_s), .tx_tdata(tdata_s),
        .tx_tvalid(tvalid_s), .tx_tready(tready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [15:0] h, input logic [15:0] a);
        mode = m; hp = h; amp = a; en = 1'b1;
        tick();
    endtask

    task automatic stop_run();
        en = 1'b0; tready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if (tvalid !== 1'b0 || tdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out: got tvalid=%b tdata=%h expected 0/00000000", tvalid, tdata);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        vectors++;
        if (tvalid !== 1'b0 || tvalid_s !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got tvalid=%b/%b expected 0/0", tvalid, tvalid_s);
        end
    endtask

    task automatic test_square();
        logic [31:0] exp_sq [8];
        exp_sq = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 32'h0,
                   32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0, 32'h0};
        tready = 1'b1;
        start_run(MODE_SQUARE, 16'd2, 16'hAAAA);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tvalid !== 1'b1 || tdata !== exp_sq[i]) begin
                miscompares++;
                $display("FAIL square beat %0d: got tvalid=%b tdata=%h expected 1/%h", i, tvalid, tdata, exp_sq[i]);
            end
            tick();
        end
        stop_run();
        vectors++;
        if (tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL square_stop: got tvalid=%b expected 0", tvalid);
        end
    endtask

    task automatic test_hp_zero();
        logic [31:0] exp_z [4];
        exp_z = '{32'h55555555, 32'h0, 32'h55555555, 32'h0};
        tready = 1'b1;
        start_run(MODE_SQUARE, 16'd0, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tdata !== exp_z[i]) begin
                miscompares++;
                $display("FAIL hp_zero beat %0d: got %h expected %h", i, tdata, exp_z[i]);
            end
            tick();
        end
        stop_run();
    endtask

    task automatic test_ramp_backpressure();
        logic [15:0] iv;
        iv = 16'h0;
        tready = 1'b1;
        start_run(MODE_RAMP, 16'd0, 16'h0);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (tvalid !== 1'b1 || tdata !== {iv, ~iv}) begin
                miscompares++;
                $display("FAIL ramp step %0d: got tvalid=%b tdata=%h expected 1/%h", k, tvalid, tdata, {iv, ~iv});
            end
            tready = (k % 2 == 0);
            tick();
            if (tready) iv = iv + 16'h1;
        end
        stop_run();
    endtask

    task automatic test_drain();
        tready = 1'b0;
        start_run(MODE_CONST, 16'd0, 16'hBEEF);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (tvalid !== 1'b1 || tdata !== 32'hBEEFBEEF || dut.state_reg !== ST_DRAIN) begin
                miscompares++;
                $display("FAIL drain_hold %0d: got tvalid=%b tdata=%h state=%0d expected 1/beefbeef/%0d",
                         k, tvalid, tdata, dut.state_reg, ST_DRAIN);
            end
        end
        tready = 1'b1;
        tick();
        vectors++;
        if (tvalid !== 1'b0 || dut.state_reg !== ST_IDLE) begin
            miscompares++;
            $display("FAIL drain_exit: got tvalid=%b state=%0d expected 0/%0d", tvalid, dut.state_reg, ST_IDLE);
        end
    endtask

    task automatic test_shadow();
        tready = 1'b1;
        start_run(MODE_CONST, 16'd0, 16'h4321);
        mode = MODE_RAMP; amp = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (tdata !== 32'h43214321) begin
                miscompares++;
                $display("FAIL shadow_hold %0d: got %h expected 43214321", k, tdata);
            end
            tick();
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        vectors++;
        if (tvalid !== 1'b1 || tdata !== 32'h0000FFFF) begin
            miscompares++;
            $display("FAIL shadow_relatch0: got tvalid=%b tdata=%h expected 1/0000ffff", tvalid, tdata);
        end
        tick();
        vectors++;
        if (tdata !== 32'h0001FFFE) begin
            miscompares++;
            $display("FAIL shadow_relatch1: got %h expected 0001fffe", tdata);
        end
        stop_run();
    endtask

    task automatic test_async_reset();
        tready = 1'b1;
        start_run(MODE_RAMP, 16'd0, 16'h0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tvalid !== 1'b0 || tdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got tvalid=%b tdata=%h expected 0/00000000", tvalid, tdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (tvalid !== 1'b1 || tdata !== 32'h0000FFFF) begin
            miscompares++;
            $display("FAIL restart_after_reset: got tvalid=%b tdata=%h expected 1/0000ffff", tvalid, tdata);
        end
        stop_run();
    endtask

    task automatic test_prbs();
        logic [31:0] exp_p [4];
`ifdef TEST_PATTERN_GEN_PRBS_EN
        exp_p = '{32'h00020000, 32'h000C0002, 32'h0028000C, 32'h00F00028};
`else
        exp_p = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
        tready = 1'b1;
        start_run(MODE_PRBS, 16'd0, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tvalid !== 1'b1 || tdata !== exp_p[i]) begin
                miscompares++;
                $display("FAIL prbs beat %0d: got tvalid=%b tdata=%h expected 1/%h", i, tvalid, tdata, exp_p[i]);
            end
            tick();
        end
        stop_run();
    endtask

    task automatic test_narrow_wrap();
        logic [3:0] v;
        tready = 1'b1;
        start_run(MODE_RAMP, 16'd0, 16'h0);
        for (int i = 0; i < 17; i++) begin
            v = 4'(i);
            vectors++;
            if (tdata_s !== {v, ~v}) begin
                miscompares++;
                $display("FAIL narrow_ramp beat %0d: got %h expected %h", i, tdata_s, {v, ~v});
            end
            tick();
        end
        stop_run();
        hp_s = 3'd7; amp_s = 4'h9;
        start_run(MODE_SQUARE, 16'd1, 16'h0);
        for (int i = 0; i < 15; i++) begin
            v = (i < 7 || i == 14) ? 4'h9 : 4'h0;
            vectors++;
            if (tdata_s !== {v, v}) begin
                miscompares++;
                $display("FAIL narrow_hp_max beat %0d: got %h expected %h", i, tdata_s, {v, v});
            end
            tick();
        end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_square();
        test_hp_zero();
        test_ramp_backpressure();
        test_drain();
        test_shadow();
        test_async_reset();
        test_prbs();
        test_narrow_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter SAMP_W, default 16, width of each I and Q component.
REQ-002 Parameter PER_W, default 16, width of the half-period counter.
REQ-003 Port radio_clk, input, 1: sole clock; all logic SHALL be on its rising edge.
REQ-004 Port radio_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: generator enable.
REQ-006 Port mode, input, 2: pattern select, sampled per REQ-011.
REQ-007 Port half_period, input, PER_W: beats per square-wave half cycle.
REQ-008 Port amplitude, input, SAMP_W: high level for square and constant modes.
REQ-009 Port tx_tdata, output, 2*SAMP_W: I in [2*SAMP_W-1:SAMP_W], Q in [SAMP_W-1:0], registered.
REQ-010 Ports tx_tvalid output 1 and tx_tready input 1: stream handshake; a beat transfers when both are high on a rising edge.

Function
REQ-011 mode, half_period and amplitude SHALL be latched into shadow registers on the cycle en is sampled 0->1; changes while en is high SHALL be ignored.
REQ-012 States IDLE, RUN, DRAIN: IDLE->RUN on en rising, tx_tvalid high the following cycle (1-cycle latency); RUN->DRAIN on en low with tx_tvalid high and no transfer; RUN or DRAIN->IDLE on the first transfer, or cycle, with en low.
REQ-013 While tx_tvalid is high and tx_tready low, tx_tdata and tx_tvalid SHALL hold; tx_tvalid SHALL never drop without a transfer.
REQ-014 Next data SHALL be presented the cycle after each transfer; back-to-back transfers at one beat per cycle SHALL be sustained with tx_tready held high.
REQ-015 Mode 0 (square): I=Q=amplitude for half_period transferred beats, then I=Q=0 for half_period beats, repeating; first beat after IDLE is high.
REQ-016 half_period=0 SHALL behave as 1; counter SHALL wrap without overflow at 2^PER_W-1.
REQ-017 Mode 1 (ramp): I starts at 0 and increments by 1 per transfer, wrapping modulo 2^SAMP_W; Q = bitwise NOT I.
REQ-018 Mode 2 (constant): I=Q=amplitude every beat.
REQ-019 Mode 3 (PRBS): see REQ-024/025.
REQ-020 Ramp value, square phase and PRBS state SHALL restart from reset values on every IDLE->RUN transition.

Reset
REQ-021 On radio_rst_n low, asynchronously: state IDLE, tx_tvalid=0, tx_tdata=0, phase counter=0, ramp=0, PRBS state=15'h7FFF, shadow registers=0.
REQ-022 Reset asserted mid-transfer SHALL abort the beat; no output holds its value through reset.
REQ-023 After release, nothing SHALL be emitted until en is sampled 0->1; en already high at release counts as a rising edge on the first clock.

Configuration
REQ-024 With TEST_PATTERN_GEN_PRBS_EN defined, mode 3 emits PRBS-15 (x^15+x^14+1), advancing SAMP_W bits per transfer; I = new SAMP_W bits, Q = previous I.
REQ-025 Without TEST_PATTERN_GEN_PRBS_EN, mode 3 SHALL emit I=Q=0 and no LFSR logic SHALL be synthesised.

Structure
REQ-026 Package test_pattern_pkg SHALL hold mode encodings (MODE_SQUARE=0, MODE_RAMP=1, MODE_CONST=2, MODE_PRBS=3), FSM state typedef, PRBS seed and tap constants.
REQ-027 Sub-module prbs15_lfsr (advance input, SAMP_W-bit parallel output) SHALL be instantiated only under TEST_PATTERN_GEN_PRBS_EN.

Verification
REQ-028 Mode 0, half_period=2, amplitude=16'hAAAA, tready=1 -> tdata AAAAAAAA, AAAAAAAA, 0, 0, repeating; tvalid high 1 cycle after en rises.
REQ-029 Mode 1, tready toggled 1,0,1,0 -> I sequence 0,1,2,... with each value held while tready=0; Q=FFFF,FFFE,...; wrap FFFF->0000 checked.
REQ-030 en dropped while tvalid=1, tready=0 for 5 cycles -> data held, DRAIN entered; tready=1 -> one transfer, then tvalid=0, IDLE.
REQ-031 Mode 2 running, mode changed to 1 and amplitude to 16'h1234 with en high -> output stays at old amplitude; after en 0->1 ramp from 0.
REQ-032 radio_rst_n pulsed low mid-stream, asynchronous to clock -> tvalid and tdata 0 immediately; restart after en edge gives first-beat values.
REQ-033 Mode 3 with macro: first 4 beats match golden PRBS-15 from seed 7FFF; without macro: tdata=0 with tvalid=1.
